// File: rtl/bram_stream_reader.sv
// Read-side initiator for a 256x16 BRAM port: issues credit-limited reads and re-times RDATA into a valid/ready stream.
// Optional macro BRAM_RD_WRAP_EN: bursts restart at base_addr forever; a start while running stops them.
module bram_stream_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic [ADDR_W-1:0] raddr,
   output logic              read_en,
   output logic              rclke,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
);

`ifdef BRAM_RD_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   issued_q, issued_d;
   logic               inflight_q, inflight_d;
   logic [1:0]         count_q, count_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]  hold_q, hold_d;
   logic [DATA_W-1:0]  fifo_mem [2];

   logic               start_ok;
   logic               stop_req;
   logic               last_rd;
   logic               credit_ok;
   logic               rd_fire;
   logic               fifo_empty;
   logic               bypass;
   logic               push;
   logic               pop;
   logic [DATA_W-1:0]  head;
   logic [DATA_W-1:0]  m_data_c;

   // Control and credit decode
   always_comb begin
      start_ok   = start && (state_q == S_IDLE);
      stop_req   = WRAP_EN && start && (state_q == S_RUN);
      last_rd    = (issued_q == len_q - LEN_W'(1));
      credit_ok  = ((count_q + {1'b0, inflight_q}) < 2'd2);
      rd_fire    = (state_q == S_RUN) && credit_ok && !stop_req;
      fifo_empty = (count_q == 2'd0);
      // A word arriving into an empty FIFO is shown immediately and skips storage if taken.
      bypass     = fifo_empty && inflight_q && m_ready;
      push       = inflight_q && !bypass;
      pop        = !fifo_empty && m_ready;
      head       = fifo_mem[rd_ptr_q];
      if (!fifo_empty) begin
         m_data_c = head;
      end else if (inflight_q) begin
         m_data_c = rdata;
      end else begin
         m_data_c = hold_q;
      end
   end

   // Datapath next-state
   always_comb begin
      base_d     = base_q;
      len_d      = len_q;
      issued_d   = issued_q;
      inflight_d = rd_fire;
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      hold_d     = m_data_c;
      if (start_ok) begin
         base_d   = base_addr;
         len_d    = (length > MAX_LEN) ? MAX_LEN : length;
         issued_d = '0;
      end else if (rd_fire) begin
         issued_d = last_rd ? '0 : issued_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         hold_q     <= '0;
      end else begin
         base_q     <= base_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         hold_q     <= hold_d;
      end
   end

   // Two-entry output FIFO storage
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DATA_W-1:0] ent_q, ent_d;

      always_comb begin
         ent_d = ent_q;
         if (push && (wr_ptr_q == 1'(gi))) begin
            ent_d = rdata;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ent_q <= '0;
         end else begin
            ent_q <= ent_d;
         end
      end

      assign fifo_mem[gi] = ent_q;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (stop_req) begin
               state_d = S_DRAIN;
            end else if (rd_fire && last_rd && !WRAP_EN) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((count_d == 2'd0) && !inflight_d) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      read_en = rd_fire;
      rclke   = rd_fire;
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
      m_valid = !fifo_empty || inflight_q;
      m_data  = m_data_c;
      raddr   = base_q + issued_q[ADDR_W-1:0];
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: BRAM model, table-driven bursts, directed corner sequences, random bursts.
module tb_bram_stream_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  length;
   logic [7:0]  raddr;
   logic        read_en;
   logic        rclke;
   logic [15:0] rdata;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic        done;

   bram_stream_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .raddr     (raddr),
      .read_en   (read_en),
      .rclke     (rclke),
      .rdata     (rdata),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // BRAM read port: registered RDATA, one cycle after an enabled read
   logic [15:0] ram [256];
   always @(posedge clk) begin
      if (read_en && rclke) rdata <= ram[raddr];
   end

   int          vectors = 0;
   int          errors  = 0;
   logic [15:0] got   [$];
   logic [7:0]  addrs [$];
   logic [15:0] mdat  [$];
   int          re_cyc[$];
   int          mv_cyc[$];
   int          done_cyc;
   int          n_done;

   typedef struct {
      logic [7:0]  b;
      logic [8:0]  l;
      int          pct;
      int          exp_n;
      logic [15:0] exp_first;
      logic [15:0] exp_last;
   } vec_t;
   vec_t tbl [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_raddr"},   raddr,   0);
      chk({tag, "_read_en"}, read_en, 0);
      chk({tag, "_rclke"},   rclke,   0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"},  m_data,  0);
      chk({tag, "_busy"},    busy,    0);
      chk({tag, "_done"},    done,    0);
   endtask

   // Runs one burst; cycle 0 is the start cycle. m_ready is 0 for cycles < stall, then random at pct%.
   task automatic run_burst(input logic [7:0] b, input logic [8:0] l, input int pct, input int stall);
      int   bound;
      bit   hit;
      logic prev_v, prev_r;
      logic [15:0] prev_d;
      got.delete(); addrs.delete(); mdat.delete(); re_cyc.delete(); mv_cyc.delete();
      done_cyc = -1; n_done = 0; hit = 0;
      prev_v = 0; prev_r = 0; prev_d = '0;
      bound = 10 * int'(l) + stall + 40;
      base_addr = b; length = l; start = 1'b1;
      for (int c = 0; c < bound; c++) begin
         if (c == 1) start = 1'b0;
         m_ready = (c < stall) ? 1'b0 : ($urandom_range(99) < pct);
         if (read_en) begin
            re_cyc.push_back(c);
            addrs.push_back(raddr);
            chk("rclke_eq_read_en", rclke, read_en);
         end
         if (m_valid) mv_cyc.push_back(c);
         mdat.push_back(m_data);
         if (m_valid && m_ready) got.push_back(m_data);
         if (prev_v && !prev_r) begin
            chk("stall_hold_valid", m_valid, 1);
            chk("stall_hold_data",  m_data,  prev_d);
         end
         prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
         if (done) begin
            n_done++; done_cyc = c; hit = 1;
            break;
         end
         tick();
      end
      start = 1'b0;
      if (!hit) begin
         vectors++; errors++;
         $display("FAIL burst_timeout: base %0h len %0d no done within %0d cycles", b, l, bound);
         rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      tick();
      m_ready = 1'b0;
   endtask

   // Reference: a burst yields ram[(base+i) mod 256] for i below min(length, 256), each read exactly once.
   task automatic check_model(input string tag, input logic [7:0] b, input logic [8:0] l);
      int n;
      logic [7:0] a;
      n = (l > 9'd256) ? 256 : int'(l);
      chk({tag, "_words"}, got.size(),   n);
      chk({tag, "_reads"}, addrs.size(), n);
      chk({tag, "_done_pulses"}, n_done, 1);
      for (int i = 0; i < n; i++) begin
         a = b + 8'(i);
         if (i < got.size())   chk($sformatf("%s_data%0d", tag, i), got[i],   ram[a]);
         if (i < addrs.size()) chk($sformatf("%s_addr%0d", tag, i), addrs[i], a);
      end
   endtask

   initial begin
      logic [7:0]  rb;
      logic [8:0]  rl;
      logic [7:0]  iv;
      int          early;

      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         ram[i] = {iv, ~iv};
      end
      ram[8'h00] = 16'h0000; ram[8'h01] = 16'h0000; ram[8'h02] = 16'h0000;
      for (int i = 8'h10; i <= 8'h13; i++) ram[i] = 16'h0002;
      ram[8'hFE] = 16'hF814; ram[8'hFF] = 16'hF820;

      repeat (3) tick();
      chk_reset_outputs("in_reset");
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_raddr", raddr, 0);
         chk("idle_read_en", read_en, 0);
         chk("idle_m_valid", m_valid, 0);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
      end

`ifdef BRAM_RD_WRAP_EN
      // Wrap: base 0 len 3 streams 00,01,02,00,... back-to-back until a start stops it
      got.delete(); addrs.delete();
      base_addr = 8'h00; length = 9'd3; m_ready = 1'b1; start = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c == 1) start = 1'b0;
         if (read_en) addrs.push_back(raddr);
         if (m_valid && m_ready) got.push_back(m_data);
         tick();
      end
      chk("wrap_reads_seen", addrs.size() >= 8, 1);
      for (int i = 0; i < 8 && i < addrs.size(); i++) chk($sformatf("wrap_addr%0d", i), addrs[i], i % 3);
      for (int i = 0; i < got.size(); i++) chk($sformatf("wrap_data%0d", i), got[i], 0);
      start = 1'b1; n_done = 0;
      for (int c = 0; c < 30; c++) begin
         if (read_en) addrs.push_back(raddr);
         if (m_valid && m_ready) got.push_back(m_data);
         if (done) begin
            n_done++;
            break;
         end
         tick();
         if (c == 0) start = 1'b0;
      end
      start = 1'b0;
      chk("wrap_stop_done", n_done, 1);
      chk("wrap_no_loss", got.size(), addrs.size());
      tick();
      chk("wrap_idle_after_stop", busy, 0);
`else
      // Timing of a plain burst: reads on cycles 1..4, valid on 2..5, done on 6
      run_burst(8'h10, 9'd4, 100, 0);
      chk("A_nreads", re_cyc.size(), 4);
      chk("A_nvalid", mv_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < re_cyc.size()) chk($sformatf("A_read_cycle%0d", i), re_cyc[i], i + 1);
         if (i < mv_cyc.size()) chk($sformatf("A_valid_cycle%0d", i), mv_cyc[i], i + 2);
      end
      chk("A_done_cycle", done_cyc, 6);
      check_model("A", 8'h10, 9'd4);

      // Consumer stalled for cycles 0..6: only two reads may issue, head stays 0002
      run_burst(8'h10, 9'd4, 100, 7);
      early = 0;
      foreach (re_cyc[i]) if (re_cyc[i] <= 6) early++;
      chk("stall_reads_during_stall", early, 2);
      if (mdat.size() > 6) chk("stall_m_data_c6", mdat[6], 16'h0002);
      check_model("stall", 8'h10, 9'd4);

      // length 0: no reads, done the cycle after start
      run_burst(8'h33, 9'd0, 100, 0);
      chk("len0_done_cycle", done_cyc, 1);
      chk("len0_no_reads", addrs.size(), 0);

      tbl[0] = '{8'h10, 9'd4,   100, 4,   16'h0002, 16'h0002};
      tbl[1] = '{8'hFE, 9'd4,   100, 4,   16'hF814, 16'h0000};
      tbl[2] = '{8'h20, 9'd300, 100, 256, 16'h20DF, 16'h1FE0};
      tbl[3] = '{8'h80, 9'd1,   100, 1,   16'h807F, 16'h807F};
      tbl[4] = '{8'hF0, 9'd256, 50,  256, 16'hF00F, 16'hEF10};
      tbl[5] = '{8'h30, 9'd2,   60,  2,   16'h30CF, 16'h31CE};
      tbl[6] = '{8'hFF, 9'd3,   70,  3,   16'hF820, 16'h0000};
      for (int i = 0; i < 7; i++) begin
         run_burst(tbl[i].b, tbl[i].l, tbl[i].pct, 0);
         chk($sformatf("tbl%0d_count", i), got.size(), tbl[i].exp_n);
         if (got.size() > 0) begin
            chk($sformatf("tbl%0d_first", i), got[0], tbl[i].exp_first);
            chk($sformatf("tbl%0d_last", i),  got[got.size()-1], tbl[i].exp_last);
         end
         check_model($sformatf("tbl%0d", i), tbl[i].b, tbl[i].l);
      end

      // Reset asserted while the second word is on the stream
      base_addr = 8'h10; length = 9'd4; m_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      chk("mid_second_word_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mid_reset_no_done", done, 0);
      end
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         chk("post_reset_no_done", done, 0);
         tick();
      end
      m_ready = 1'b0;
      run_burst(8'h40, 9'd5, 100, 0);
      check_model("after_reset", 8'h40, 9'd5);

      for (int k = 0; k < 25; k++) begin
         rb = 8'($urandom_range(0, 255));
         rl = 9'($urandom_range(0, 300));
         run_burst(rb, rl, $urandom_range(40, 100), $urandom_range(0, 3));
         check_model($sformatf("rnd%0d", k), rb, rl);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
